// File: rtl/pcie_rx_descrambler.sv
// pcie_rx_descrambler
//   Gen1/2 x1 receive descrambler that handles two 8b10b-decoded symbols per clock.
//   It sits between the RX CDC FIFO and the LTSSM / data link layer. The block runs
//   the x^16+x^5+x^4+x^3+1 LFSR. A COM reseeds the LFSR, a SKP holds it, and every
//   other symbol advances it by 8 bits. D-chars outside training-set bodies are
//   XORed with the scramble byte. K flags and error flags travel with the data.
//   Latency is one clock on every cycle.
//
// Optional feature (compile-time macro): PCIE_RX_DESCRAMBLE_ERRCNT_EN
//   When defined, the err_count port and a saturating errored-symbol counter are
//   present. When undefined, both are absent.
//
// Ports
//   clk           in   1              single clock
//   rst_n         in   1              asynchronous active-low reset
//   rx_data       in   16             [7:0] symbol 0 (earlier), [15:8] symbol 1
//   rx_charisk    in   2              per-symbol K flag
//   rx_err        in   2              per-symbol disparity/symbol error
//   scramble_dis  in   1              1 = do not XOR (LFSR keeps running)
//   out_data      out  16             descrambled symbols, same ordering
//   out_charisk   out  2              rx_charisk delayed one clock
//   out_err       out  2              rx_err delayed one clock
//   out_in_ts     out  2              symbol lies in a TS1/TS2 body
//   err_count     out  ERR_CNT_WIDTH  saturating errored-symbol count (macro only)
module pcie_rx_descrambler #(
  parameter logic [15:0] LFSR_SEED     = 16'hFFFF,
  parameter int          ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              rx_data,
  input  logic [1:0]               rx_charisk,
  input  logic [1:0]               rx_err,
  input  logic                     scramble_dis,
  output logic [15:0]              out_data,
  output logic [1:0]               out_charisk,
  output logic [1:0]               out_err,
  output logic [1:0]               out_in_ts
`ifdef PCIE_RX_DESCRAMBLE_ERRCNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] err_count
`endif
);

  if (ERR_CNT_WIDTH < 1) begin : g_bad_width
    $error("ERR_CNT_WIDTH must be at least 1");
  end

  typedef struct packed {
    logic [15:0] lfsr;
    logic [3:0]  ts;      // body symbols still to come after this one
    logic        com;
    logic        in_ts;
    logic [7:0]  dout;
  } slot_t;

  // One serial LFSR step. The output bit is taken from bit 15 before the step.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n    = {s[14:0], s[15]};
    n[3] = s[2] ^ s[15];
    n[4] = s[3] ^ s[15];
    n[5] = s[4] ^ s[15];
    return n;
  endfunction

  // Scramble byte. The first output bit goes to the byte LSB.
  function automatic logic [7:0] scr_byte(input logic [15:0] s);
    logic [7:0]  b;
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      b[i] = t[15];
      t    = lfsr_step(t);
    end
    return b;
  endfunction

  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) t = lfsr_step(t);
    return t;
  endfunction

  // Processes one symbol in time order.
  // A training-set body is recognised by a K-char (PAD) directly after COM that is
  // not SKP/FTS/IDL. A D-char directly after COM is ordinary scrambled data.
  // FTS and IDL are matched without qualifying the error flag. COM and SKP are
  // recognised only when error-free.
  function automatic slot_t slot_step(input logic [7:0]  d,
                                      input logic        k,
                                      input logic        e,
                                      input logic        dis,
                                      input logic [15:0] lfsr,
                                      input logic [3:0]  ts,
                                      input logic        prev_com);
    slot_t r;
    logic  com, skp, ord, start;
    com     = k && (d == 8'hBC) && !e;
    skp     = k && (d == 8'h1C) && !e;
    ord     = k && ((d == 8'h3C) || (d == 8'h7C));
    start   = prev_com && k && !skp && !ord;
    r.com   = com;
    r.dout  = d;
    r.in_ts = 1'b0;
    r.lfsr  = lfsr;
    r.ts    = ts;
    if (com) begin
      r.lfsr = LFSR_SEED;
      r.ts   = 4'd0;
    end else begin
      r.in_ts = start || (ts != 4'd0);
      if (start)             r.ts = 4'd14;
      else if (ts != 4'd0)   r.ts = ts - 4'd1;
      if (!skp) begin
        if (!k && !r.in_ts && !dis) r.dout = d ^ scr_byte(lfsr);
        r.lfsr = lfsr_adv8(lfsr);
      end
    end
    return r;
  endfunction

  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  ts_cnt_q, ts_cnt_d;
  logic        com_pend_q, com_pend_d;
  logic [15:0] out_data_q, out_data_d;
  logic [1:0]  out_charisk_q, out_charisk_d;
  logic [1:0]  out_err_q, out_err_d;
  logic [1:0]  out_in_ts_q, out_in_ts_d;
  slot_t       s0, s1;

  // Slot 0 sees the COM carried over from the previous clock. Slot 1 sees slot 0.
  always_comb begin
    s0 = slot_step(rx_data[7:0], rx_charisk[0], rx_err[0], scramble_dis,
                   lfsr_q, ts_cnt_q, com_pend_q);
    s1 = slot_step(rx_data[15:8], rx_charisk[1], rx_err[1], scramble_dis,
                   s0.lfsr, s0.ts, s0.com);
    lfsr_d        = s1.lfsr;
    ts_cnt_d      = s1.ts;
    com_pend_d    = s1.com;
    out_data_d    = {s1.dout, s0.dout};
    out_charisk_d = rx_charisk;
    out_err_d     = rx_err;
    out_in_ts_d   = {s1.in_ts, s0.in_ts};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q        <= LFSR_SEED;
      ts_cnt_q      <= 4'd0;
      com_pend_q    <= 1'b0;
      out_data_q    <= 16'd0;
      out_charisk_q <= 2'd0;
      out_err_q     <= 2'd0;
      out_in_ts_q   <= 2'd0;
    end else begin
      lfsr_q        <= lfsr_d;
      ts_cnt_q      <= ts_cnt_d;
      com_pend_q    <= com_pend_d;
      out_data_q    <= out_data_d;
      out_charisk_q <= out_charisk_d;
      out_err_q     <= out_err_d;
      out_in_ts_q   <= out_in_ts_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_charisk = out_charisk_q;
  assign out_err     = out_err_q;
  assign out_in_ts   = out_in_ts_q;

`ifdef PCIE_RX_DESCRAMBLE_ERRCNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_WIDTH:0]   err_sum;

  // At most 2 is added per clock, so one carry bit is enough to detect overflow.
  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + (ERR_CNT_WIDTH+1)'(rx_err[0])
                                  + (ERR_CNT_WIDTH+1)'(rx_err[1]);
    err_cnt_d = err_sum[ERR_CNT_WIDTH] ? {ERR_CNT_WIDTH{1'b1}}
                                       : err_sum[ERR_CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_pcie_rx_descrambler.sv
// Testbench for pcie_rx_descrambler.
//   The reference model represents the scrambler as a precomputed byte sequence,
//   generated by a Galois-form LFSR and indexed by the count of advancing symbols
//   since the last seed. Each cycle, a compare process checks the registered
//   outputs against the model. Literal expectations pin both the sequence and the
//   key DUT outputs.
module tb_pcie_rx_descrambler;
  localparam int ECW  = 4;
  localparam int TABN = 256;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [15:0]    rx_data = '0;
  logic [1:0]     rx_charisk = '0;
  logic [1:0]     rx_err = '0;
  logic           scramble_dis = 1'b0;
  logic [15:0]    out_data;
  logic [1:0]     out_charisk, out_err, out_in_ts;
`ifdef PCIE_RX_DESCRAMBLE_ERRCNT_EN
  logic [ECW-1:0] err_count;
`endif

  pcie_rx_descrambler #(.LFSR_SEED(16'hFFFF), .ERR_CNT_WIDTH(ECW)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_charisk(rx_charisk),
    .rx_err(rx_err), .scramble_dis(scramble_dis), .out_data(out_data),
    .out_charisk(out_charisk), .out_err(out_err), .out_in_ts(out_in_ts)
`ifdef PCIE_RX_DESCRAMBLE_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference scramble sequence and model state
  logic [7:0]  tab [TABN];
  int          m_pos = 0;
  int          m_body = 0;
  bit          m_prev_com = 0;
  int          m_ecnt = 0;

  logic [15:0] exp_data = '0;
  logic [1:0]  exp_k = '0, exp_e = '0, exp_ts = '0;
  int          exp_cnt = 0;
  bit          chk_en = 0;

  initial begin : gen_tab
    logic [15:0] s;
    logic        fb;
    s = 16'hFFFF;
    for (int n = 0; n < TABN; n++) begin
      for (int b = 0; b < 8; b++) begin
        fb = s[15];
        tab[n][b] = fb;
        s = {s[14:0], 1'b0} ^ (fb ? 16'h0039 : 16'h0000);
      end
    end
  end

  task automatic model_reset();
    m_pos = 0; m_body = 0; m_prev_com = 0; m_ecnt = 0;
    exp_data = '0; exp_k = '0; exp_e = '0; exp_ts = '0; exp_cnt = 0;
  endtask

  task automatic model_sym(input logic [7:0] d, input logic k, input logic e, input logic dis,
                           output logic [7:0] o, output logic t);
    bit com, skp, ord, start;
    com = k && (d == 8'hBC) && !e;
    skp = k && (d == 8'h1C) && !e;
    ord = k && ((d == 8'h3C) || (d == 8'h7C));
    o = d;
    t = 1'b0;
    if (com) begin
      m_pos = 0; m_body = 0; m_prev_com = 1;
    end else begin
      start = m_prev_com && k && !skp && !ord;
      t = start || (m_body > 0);
      if (start) m_body = 14;
      else if (m_body > 0) m_body--;
      if (!skp) begin
        if (!k && !t && !dis) o = d ^ tab[m_pos % TABN];
        m_pos++;
      end
      m_prev_com = 0;
    end
  endtask

  // Drive one clock of input. Returns 1 time unit after the capturing edge,
  // with the expectation for that edge in place.
  task automatic step(input logic [7:0] d0, input logic k0, input logic [7:0] d1,
                      input logic k1, input logic [1:0] e, input logic dis);
    logic [7:0] o0, o1;
    logic       t0, t1;
    int         nc;
    rx_data = {d1, d0}; rx_charisk = {k1, k0}; rx_err = e; scramble_dis = dis;
    model_sym(d0, k0, e[0], dis, o0, t0);
    model_sym(d1, k1, e[1], dis, o1, t1);
    nc = m_ecnt + int'(e[0]) + int'(e[1]);
    m_ecnt = (nc > (2**ECW - 1)) ? (2**ECW - 1) : nc;
    @(posedge clk); #1;
    exp_data = {o1, o0}; exp_k = {k1, k0}; exp_e = e; exp_ts = {t1, t0};
    exp_cnt = m_ecnt;
    chk_en = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_data", 32'(out_data), 32'(exp_data));
      chk("out_charisk", 32'(out_charisk), 32'(exp_k));
      chk("out_err", 32'(out_err), 32'(exp_e));
      chk("out_in_ts", 32'(out_in_ts), 32'(exp_ts));
`ifdef PCIE_RX_DESCRAMBLE_ERRCNT_EN
      chk("err_count", 32'(err_count), 32'(exp_cnt));
`endif
    end
  end

  task automatic reset_sync();
    rst_n = 0;
    model_reset();
    rx_data = '0; rx_charisk = '0; rx_err = '0; scramble_dis = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    model_reset();
    #1 chk_en = 1;
    // Pin the reference sequence.
    chk("tab0", 32'(tab[0]), 32'hFF);
    chk("tab1", 32'(tab[1]), 32'h17);
    chk("tab2", 32'(tab[2]), 32'hC0);
    reset_sync();
    chk("reset_data", 32'(out_data), 32'h0);

    // COM then D: D bytes descramble with FF, 17, C0.
    step(8'hBC, 1, 8'h00, 0, 2'b00, 0);
    chk("com_first", 32'(out_data), 32'hFFBC);
    chk("com_k", 32'(out_charisk), 32'h1);
    step(8'h00, 0, 8'h00, 0, 2'b00, 0);
    chk("com_next", 32'(out_data), 32'hC017);

    // SKPs hold the LFSR.
    step(8'hBC, 1, 8'h1C, 1, 2'b00, 0);
    step(8'h1C, 1, 8'h00, 0, 2'b00, 0);
    chk("skp_hold", 32'(out_data), 32'hFF1C);
    chk("skp_k", 32'(out_charisk), 32'h1);

    // TS1: COM, PAD, PAD, N_FTS, rate, ctl, ten 4A.
    step(8'hBC, 1, 8'hF7, 1, 2'b00, 0);
    chk("ts_start", 32'(out_in_ts), 32'h2);
    step(8'hF7, 1, 8'h11, 0, 2'b00, 0);
    step(8'h02, 0, 8'h00, 0, 2'b00, 0);
    chk("ts_ctl_bypass", 32'(out_data), 32'h0002);
    for (int i = 0; i < 5; i++) step(8'h4A, 0, 8'h4A, 0, 2'b00, 0);
    chk("ts_last", 32'(out_in_ts), 32'h3);
    chk("ts_last_data", 32'(out_data), 32'h4A4A);
    step(8'h00, 0, 8'h00, 0, 2'b00, 0);
    chk("ts_after", 32'(out_in_ts), 32'h0);

    // COM in slot 1 applies to slot 0 of the next clock.
    step(8'h00, 0, 8'hBC, 1, 2'b00, 0);
    step(8'h00, 0, 8'h00, 0, 2'b00, 0);
    chk("com_pend", 32'(out_data), 32'h17FF);

    // scramble_dis gates only the XOR.
    step(8'hBC, 1, 8'h00, 0, 2'b00, 1);
    chk("dis_com", 32'(out_data), 32'h00BC);
    step(8'h00, 0, 8'h00, 0, 2'b00, 1);
    chk("dis_data", 32'(out_data), 32'h0000);
    step(8'h00, 0, 8'h00, 0, 2'b00, 0);
    step(8'h00, 0, 8'h00, 0, 2'b00, 0);

    // Two COMs in one clock, followed by data.
    step(8'hBC, 1, 8'hBC, 1, 2'b00, 0);
    step(8'h00, 0, 8'h00, 0, 2'b00, 0);
    chk("two_com", 32'(out_data), 32'h17FF);

    // Errored COM and errored SKP both advance the LFSR. FTS after COM does not start a body.
    step(8'hBC, 1, 8'h00, 0, 2'b01, 0);
    step(8'h00, 0, 8'h1C, 1, 2'b10, 0);
    step(8'h5A, 0, 8'hA5, 0, 2'b01, 0);
    step(8'hBC, 1, 8'h3C, 1, 2'b00, 0);
    step(8'h00, 0, 8'h7C, 1, 2'b00, 0);
    step(8'h00, 0, 8'h00, 0, 2'b00, 0);

    // Mixed traffic.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b;
      a = 8'(i * 29 + 3);
      b = 8'(i * 53 + 7);
      if (i == 6) step(a, 0, 8'hBC, 1, 2'b00, 0);
      else        step(a, (i % 4) == 1, b, 0, 2'(i % 3), 0);
    end

    // Async reset mid-stream: outputs clear immediately, and data restarts from the seed.
    step(8'h33, 0, 8'h44, 0, 2'b00, 0);
    #2 rst_n = 0;
    model_reset();
    #1 chk("async_rst", 32'(out_data), 32'h0);
    chk("async_rst_k", 32'(out_charisk), 32'h0);
    @(posedge clk); #1 rst_n = 1;
    step(8'h00, 0, 8'h00, 0, 2'b00, 0);
    chk("post_rst_seed", 32'(out_data), 32'h17FF);

`ifdef PCIE_RX_DESCRAMBLE_ERRCNT_EN
    reset_sync();
    for (int i = 0; i < 3; i++) step(8'h00, 0, 8'h00, 0, 2'b11, 0);
    step(8'h00, 0, 8'h00, 0, 2'b01, 0);
    chk("errcnt_7", 32'(err_count), 32'd7);
    for (int i = 0; i < 5; i++) step(8'h00, 0, 8'h00, 0, 2'b11, 0);
    chk("errcnt_sat", 32'(err_count), 32'd15);
    step(8'h00, 0, 8'h00, 0, 2'b11, 0);
    #2 rst_n = 0;
    model_reset();
    #1 chk("errcnt_rst", 32'(err_count), 32'd0);
    @(posedge clk); #1 rst_n = 1;
    step(8'h00, 0, 8'h00, 0, 2'b10, 0);
    chk("errcnt_restart", 32'(err_count), 32'd1);
`endif

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
